// File: rtl/pmp_pkg.sv
// Shared types for the PMP checker: address-matching modes, access kinds,
// and the pmpcfg byte layout.
package pmp_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_TOR   = 2'd1,
    MODE_NA4   = 2'd2,
    MODE_NAPOT = 2'd3
  } pmp_mode_e;

  typedef enum logic [1:0] {
    ACC_READ  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_EXEC  = 2'd2,
    ACC_RSVD  = 2'd3
  } access_e;

  localparam int CFG_R    = 0;
  localparam int CFG_W    = 1;
  localparam int CFG_X    = 2;
  localparam int CFG_A_LO = 3;
  localparam int CFG_L    = 7;

  typedef struct packed {
    logic      l;
    logic [1:0] rsvd;
    pmp_mode_e a;
    logic      x;
    logic      w;
    logic      r;
  } pmp_cfg_t;

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational region test for one PMP entry: reports whether the first
// and last byte of an access fall inside the entry's region.
module pmp_entry_match
  import pmp_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [31:0] addr,
  input  logic [31:0] prev,
  input  logic [31:0] req_addr,
  input  logic [1:0]  size,
  output logic        full,
  output logic        partial
);

  logic [33:0] first;
  logic [33:0] last;
  logic [33:0] lo;
  logic [33:0] hi;
  logic [33:0] nmask;
  logic        in_f;
  logic        in_l;

  always_comb begin
    first = {2'b00, req_addr};
    unique case (size)
      2'd0:    last = first;
      2'd1:    last = first + 34'd1;
      default: last = first + 34'd3;
    endcase
    lo = {prev, 2'b00};
    hi = {addr, 2'b00};
    // addr ^ (addr+1) sets the trailing ones plus the next bit: the NAPOT size
    nmask = ~{addr ^ (addr + 32'd1), 2'b11};
    in_f = 1'b0;
    in_l = 1'b0;
    unique case (mode)
      MODE_TOR: begin
        in_f = (first >= lo) && (first < hi);
        in_l = (last >= lo) && (last < hi);
      end
      MODE_NA4: begin
        in_f = (first[33:2] == addr);
        in_l = (last[33:2] == addr);
      end
      MODE_NAPOT: begin
        in_f = ((first ^ hi) & nmask) == 34'd0;
        in_l = ((last ^ hi) & nmask) == 34'd0;
      end
      default: ;
    endcase
  end

  assign full    = in_f & in_l;
  assign partial = in_f ^ in_l;

endmodule

// File: rtl/pmp_checker.sv
// Multi-entry PMP checker: CSR-written cfg/addr pairs, scanned one entry
// per cycle behind a valid/ready request, single allow/deny response.
module pmp_checker
  import pmp_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             csr_we,
  input  logic             csr_sel,
  input  logic [IDX_W-1:0] csr_idx,
  input  logic [31:0]      csr_wdata,
  output logic [31:0]      csr_rdata,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [1:0]       req_size,
  input  logic [1:0]       req_type,
  input  logic             req_priv_m,
  output logic             resp_valid,
  output logic             resp_allow,
  output logic             resp_match,
  output logic [IDX_W-1:0] resp_entry
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [IDX_W:0]   N_ENT = (IDX_W+1)'(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

  pmp_cfg_t    cfg  [NUM_ENTRIES];
  logic [31:0] addr [NUM_ENTRIES];

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [31:0]      q_addr;
  logic [1:0]       q_size;
  logic [1:0]       q_type;
  logic             q_priv;

  logic             idx_ok;
  logic [IDX_W:0]   nxt;
  pmp_cfg_t         nxt_cfg;
  logic             cfg_lock;
  logic             tor_lock;
  pmp_cfg_t         new_cfg;

  assign idx_ok = {1'b0, csr_idx} < N_ENT;
  assign nxt    = {1'b0, csr_idx} + {{IDX_W{1'b0}}, 1'b1};

  always_comb begin
    cfg_lock = 1'b0;
    nxt_cfg  = '0;
    if (idx_ok) cfg_lock = cfg[csr_idx].l;
    if (nxt < N_ENT) nxt_cfg = cfg[nxt[IDX_W-1:0]];
    // A locked TOR entry also freezes the base held in the entry below it
    tor_lock = nxt_cfg.l && (nxt_cfg.a == MODE_TOR);
    new_cfg = pmp_cfg_t'(csr_wdata[7:0]);
    new_cfg.rsvd = 2'b00;
    if (new_cfg.w && !new_cfg.r) new_cfg.w = 1'b0;
  end

  always_comb begin
    csr_rdata = '0;
    if (idx_ok) begin
      if (csr_sel) csr_rdata = addr[csr_idx];
      else         csr_rdata = {24'b0, cfg[csr_idx]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        cfg[i]  <= '0;
        addr[i] <= '0;
      end
    end else if (csr_we && idx_ok && !cfg_lock) begin
      if (!csr_sel) cfg[csr_idx] <= new_cfg;
      else if (!tor_lock) addr[csr_idx] <= csr_wdata;
    end
  end

  pmp_cfg_t    cur_cfg;
  logic [31:0] prev;
  logic        full;
  logic        partial;
  logic        hit;
  logic        perm;
  logic        allow_now;

  always_comb begin
    cur_cfg = cfg[idx];
    prev    = (idx == '0) ? 32'd0 : addr[idx - ONE];
  end

  pmp_entry_match u_match (
    .mode     (cur_cfg.a),
    .addr     (addr[idx]),
    .prev     (prev),
    .req_addr (q_addr),
    .size     (q_size),
    .full     (full),
    .partial  (partial)
  );

  always_comb begin
    hit  = full | partial;
    perm = cur_cfg.r;
    if (q_type == ACC_WRITE)     perm = cur_cfg.w;
    else if (q_type == ACC_EXEC) perm = cur_cfg.x;
    unique case (1'b1)
      partial: allow_now = 1'b0;
      full:    allow_now = (!cur_cfg.l && q_priv) ? 1'b1 : perm;
      default: allow_now = q_priv;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      q_addr     <= '0;
      q_size     <= '0;
      q_type     <= '0;
      q_priv     <= 1'b0;
      resp_allow <= 1'b0;
      resp_match <= 1'b0;
      resp_entry <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            q_addr <= req_addr;
            q_size <= req_size;
            q_type <= req_type;
            q_priv <= req_priv_m;
            idx    <= '0;
            state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (hit || idx == LAST) begin
            resp_allow <= allow_now;
            resp_match <= hit;
            resp_entry <= hit ? idx : '0;
            state      <= S_RESP;
          end else begin
            idx <= idx + ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

endmodule

// File: tb/tb_pmp_checker.sv
// Bench for pmp_checker: directed vector table, reset and back-to-back
// sequences, then random traffic against a region-arithmetic model.
module tb_pmp_checker;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_we = 1'b0;
  logic        csr_sel = 1'b0;
  logic [2:0]  csr_idx = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [1:0]  req_type = '0;
  logic        req_priv_m = 1'b0;
  logic        resp_valid;
  logic        resp_allow;
  logic        resp_match;
  logic [2:0]  resp_entry;

  pmp_checker #(.NUM_ENTRIES(N)) dut (
    .clk(clk), .rst(rst),
    .csr_we(csr_we), .csr_sel(csr_sel), .csr_idx(csr_idx),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size),
    .req_type(req_type), .req_priv_m(req_priv_m),
    .resp_valid(resp_valid), .resp_allow(resp_allow),
    .resp_match(resp_match), .resp_entry(resp_entry)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mcfg [N];
  logic [31:0] maddr [N];

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      mcfg[i] = 8'h00;
      maddr[i] = 32'h0;
    end
  endfunction

  function automatic void m_write(input bit sel, input int i,
                                  input logic [31:0] d);
    logic [7:0] b;
    if (mcfg[i][7]) return;
    if (sel) begin
      if (i < N-1 && mcfg[i+1][7] && mcfg[i+1][4:3] == 2'd1) return;
      maddr[i] = d;
    end else begin
      b = d[7:0] & 8'h9F;
      if (b[1] && !b[0]) b[1] = 1'b0;
      mcfg[i] = b;
    end
  endfunction

  function automatic void m_check(input logic [31:0] a, input logic [1:0] sz,
                                  input logic [1:0] ty, input bit pm,
                                  output bit allow, output bit match,
                                  output int entry, output int lat);
    longint first, last, lo, hi;
    bit inf, inl, perm;
    int t;
    first = longint'({32'b0, a});
    last = first + ((sz == 0) ? 0 : (sz == 1) ? 1 : 3);
    allow = pm; match = 0; entry = 0; lat = N + 1;
    for (int i = 0; i < N; i++) begin
      lo = 0; hi = 0;
      case (mcfg[i][4:3])
        2'd1: begin
          lo = (i == 0) ? 0 : longint'({32'b0, maddr[i-1]}) * 4;
          hi = longint'({32'b0, maddr[i]}) * 4;
        end
        2'd2: begin
          lo = longint'({32'b0, maddr[i]}) * 4;
          hi = lo + 4;
        end
        2'd3: begin
          t = 0;
          while (t < 32 && maddr[i][t]) t++;
          lo = (longint'({32'b0, maddr[i]}) >> t) << (t + 2);
          hi = lo + (longint'(1) << (t + 3));
        end
        default: ;
      endcase
      inf = (first >= lo) && (first < hi);
      inl = (last >= lo) && (last < hi);
      if (inf || inl) begin
        match = 1; entry = i; lat = i + 2;
        perm = (ty == 1) ? mcfg[i][1] : (ty == 2) ? mcfg[i][2] : mcfg[i][0];
        if (inf != inl) allow = 0;
        else if (!mcfg[i][7] && pm) allow = 1;
        else allow = perm;
        return;
      end
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic csr_write(input bit sel, input int i, input logic [31:0] d);
    @(negedge clk);
    csr_we = 1'b1; csr_sel = sel; csr_idx = 3'(i); csr_wdata = d;
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic csr_read(input bit sel, input int i, output logic [31:0] d);
    @(negedge clk);
    csr_sel = sel; csr_idx = 3'(i);
    #1 d = csr_rdata;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [1:0] sz,
                        input logic [1:0] ty, input bit pm,
                        output bit allow, output bit match,
                        output int entry, output int lat);
    @(negedge clk);
    req_addr = a; req_size = sz; req_type = ty; req_priv_m = pm;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    allow = resp_allow; match = resp_match; entry = int'(resp_entry);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int          kind;
    bit          sel;
    int          idx;
    logic [31:0] data;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [1:0]  ty;
    bit          pm;
    bit          ea;
    bit          em;
    int          ee;
    int          el;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk_w(input bit sel, input int i, input logic [31:0] d);
    vec_t v = '{0, sel, i, d, 0, 0, 0, 0, 0, 0, 0, 0};
    return v;
  endfunction

  function automatic vec_t mk_r(input bit sel, input int i, input logic [31:0] d);
    vec_t v = '{1, sel, i, d, 0, 0, 0, 0, 0, 0, 0, 0};
    return v;
  endfunction

  function automatic vec_t mk_q(input logic [31:0] a, input logic [1:0] sz,
                                input logic [1:0] ty, input bit pm, input bit ea,
                                input bit em, input int ee, input int el);
    vec_t v = '{2, 0, 0, 0, a, sz, ty, pm, ea, em, ee, el};
    return v;
  endfunction

  bit          g_allow, g_match, m_allow, m_match;
  int          g_entry, g_lat, m_entry, m_lat;
  logic [31:0] rd;
  int          acc, resps;
  bit          exp_ready;

  initial begin
    m_reset();
    tbl.push_back(mk_w(1, 0, 32'h2000_01FF));
    tbl.push_back(mk_w(0, 0, 32'h1D));
    tbl.push_back(mk_q(32'h8000_0FFC, 2, 0, 0, 1, 1, 0, 2));
    tbl.push_back(mk_q(32'h8000_0FFC, 2, 1, 0, 0, 1, 0, 2));
    tbl.push_back(mk_q(32'h8000_0FFE, 2, 0, 1, 0, 1, 0, 2));
    tbl.push_back(mk_w(1, 1, 32'h400));
    tbl.push_back(mk_w(1, 2, 32'h800));
    tbl.push_back(mk_w(0, 2, 32'h0B));
    tbl.push_back(mk_q(32'h1FFC, 2, 1, 0, 1, 1, 2, 4));
    tbl.push_back(mk_q(32'h2000, 2, 1, 0, 0, 0, 0, 9));
    tbl.push_back(mk_q(32'h2000, 2, 1, 1, 1, 0, 0, 9));
    tbl.push_back(mk_w(1, 0, 32'h100));
    tbl.push_back(mk_w(0, 1, 32'h89));
    tbl.push_back(mk_w(1, 0, 32'h12345));
    tbl.push_back(mk_w(1, 1, 32'h999));
    tbl.push_back(mk_w(0, 1, 32'h00));
    tbl.push_back(mk_r(1, 0, 32'h100));
    tbl.push_back(mk_r(1, 1, 32'h400));
    tbl.push_back(mk_r(0, 1, 32'h89));
    tbl.push_back(mk_q(32'h800, 2, 1, 1, 0, 1, 1, 3));
    tbl.push_back(mk_q(32'h800, 0, 0, 1, 1, 1, 1, 3));
    tbl.push_back(mk_q(32'h404, 1, 2, 0, 1, 1, 0, 2));
    tbl.push_back(mk_w(0, 3, 32'h02));
    tbl.push_back(mk_r(0, 3, 32'h00));
    tbl.push_back(mk_w(0, 4, 32'h7F));
    tbl.push_back(mk_r(0, 4, 32'h1F));

    repeat (3) @(negedge clk);
    chk("reset_ready", req_ready, 1);
    chk("reset_valid", resp_valid, 0);
    chk("reset_allow", resp_allow, 0);
    rst = 1'b0;
    chk("reset_match", resp_match, 0);
    chk("reset_entry", resp_entry, 0);
    csr_read(1, 0, rd);
    chk("reset_addr0", rd, 0);

    foreach (tbl[k]) begin
      case (tbl[k].kind)
        0: csr_write(tbl[k].sel, tbl[k].idx, tbl[k].data);
        1: begin
          csr_read(tbl[k].sel, tbl[k].idx, rd);
          chk($sformatf("v%0d_rdata", k), rd, tbl[k].data);
        end
        default: begin
          do_req(tbl[k].a, tbl[k].sz, tbl[k].ty, tbl[k].pm,
                 g_allow, g_match, g_entry, g_lat);
          chk($sformatf("v%0d_lat", k), g_lat, tbl[k].el);
          chk($sformatf("v%0d_allow", k), g_allow, tbl[k].ea);
          chk($sformatf("v%0d_match", k), g_match, tbl[k].em);
          chk($sformatf("v%0d_entry", k), g_entry, tbl[k].ee);
          @(negedge clk);
          chk($sformatf("v%0d_pulse", k), resp_valid, 0);
          chk($sformatf("v%0d_hold", k), resp_allow, tbl[k].ea);
        end
      endcase
    end

    // reset while scanning a no-match request
    @(negedge clk);
    req_addr = 32'h0010_0000; req_size = 2; req_type = 0; req_priv_m = 0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", resp_valid, 0);
    chk("midrst_ready", req_ready, 1);
    csr_sel = 1'b0; csr_idx = 3'd1;
    #1 chk("midrst_cfg1", csr_rdata, 0);
    csr_sel = 1'b1; csr_idx = 3'd2;
    #1 chk("midrst_addr2", csr_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    resps = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid) resps++;
    end
    chk("midrst_noresp", resps, 0);

    // back-to-back with entry-0 hits
    csr_write(1, 0, 32'h2000_01FF);
    csr_write(0, 0, 32'h1D);
    @(negedge clk);
    req_addr = 32'h8000_0000; req_size = 2; req_type = 0; req_priv_m = 0;
    req_valid = 1'b1;
    acc = 0; resps = 0; exp_ready = 0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (exp_ready) chk("b2b_ready", req_ready, 1);
      exp_ready = resp_valid;
      if (resp_valid) resps++;
      if (c == 29) req_valid = 1'b0;
      if (req_valid && req_ready) acc++;
    end
    repeat (10) begin
      @(negedge clk);
      if (resp_valid) resps++;
    end
    chk("b2b_count", resps, acc);
    chk("b2b_rate", acc, 10);

    // random traffic against the model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    for (int it = 0; it < 120; it++) begin
      int op, i;
      logic [31:0] d;
      bit sel;
      op = $urandom_range(0, 3);
      if (op < 2) begin
        sel = 1'($urandom_range(0, 1));
        i = $urandom_range(0, N-1);
        if (sel) d = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF
                                                  : $urandom_range(0, 32'h3FF);
        else d = ($urandom & 32'h7F) | (($urandom_range(0, 9) == 0) ? 32'h80 : 0);
        csr_write(sel, i, d);
        m_write(sel, i, d);
        csr_read(sel, i, rd);
        chk("rnd_rdata", rd, sel ? maddr[i] : {24'b0, mcfg[i]});
      end else begin
        logic [31:0] a;
        logic [1:0] sz, ty;
        bit pm;
        a = $urandom_range(0, 32'h1010);
        sz = 2'($urandom); ty = 2'($urandom); pm = 1'($urandom);
        m_check(a, sz, ty, pm, m_allow, m_match, m_entry, m_lat);
        do_req(a, sz, ty, pm, g_allow, g_match, g_entry, g_lat);
        chk("rnd_lat", g_lat, m_lat);
        chk("rnd_allow", g_allow, m_allow);
        chk("rnd_match", g_match, m_match);
        chk("rnd_entry", g_entry, m_entry);
        @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pmp_checker.md
Name: pmp_checker

Overview:
- Parametrised multi-entry RISC-V Physical Memory Protection checker for the core's load/store/fetch path.
- Holds NUM_ENTRIES pmpcfg/pmpaddr register pairs, written over a simple CSR port.
- Supports the OFF, TOR, NA4 and NAPOT address-matching modes, with lock semantics.
- Scans entries sequentially, one per cycle, lowest index first, behind a valid/ready request handshake, and returns a single allow/deny response.

Parameters:
- NUM_ENTRIES, 8, number of PMP entries (1..16).
- IDX_W, $clog2(NUM_ENTRIES), entry index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- csr_we  in  1  CSR write strobe.
- csr_sel  in  1  0 = pmpcfg[i] (low 8 bits of wdata), 1 = pmpaddr[i].
- csr_idx  in  IDX_W  entry index.
- csr_wdata  in  32  write data.
- csr_rdata  out  32  combinational readback of the selected register (cfg zero-extended).
- req_valid  in  1  check request.
- req_ready  out  1  high only in IDLE.
- req_addr  in  32  byte address.
- req_size  in  2  0 = 1 B, 1 = 2 B, 2 = 4 B, 3 treated as 4 B.
- req_type  in  2  0 = read, 1 = write, 2 = execute, 3 treated as read.
- req_priv_m  in  1  request issued in M-mode.
- resp_valid  out  1  one-cycle result pulse.
- resp_allow  out  1  access permitted.
- resp_match  out  1  some entry matched (full or partial).
- resp_entry  out  IDX_W  index of the matching entry (0 if none).

Behaviour:
- **Reset:** All cfg and addr registers are 0 (OFF, unlocked). State is IDLE. resp_valid, resp_allow, resp_match and resp_entry are 0, so req_ready is 1.
- **cfg byte layout:** bit0 R, bit1 W, bit2 X, bits4:3 A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), bit7 L. Bits 6:5 read as 0.
- **CSR writes:**
  - A write takes effect at the next clock edge.
  - A write to cfg[i] or addr[i] is ignored when cfg[i].L = 1.
  - A write to addr[i] is also ignored when cfg[i+1].L = 1 and cfg[i+1].A = TOR.
  - A cfg write with W = 1 and R = 0 is stored with W cleared.
- **Arithmetic:**
  - All region math is done in 34 bits, with byte address = pmpaddr << 2.
  - last = req_addr + size - 1, zero-extended; there is no wrap.
- **Region per mode:**
  - TOR: base = (i == 0 ? 0 : addr[i-1] << 2), top = addr[i] << 2. A byte is in the region when base <= byte < top. If base >= top the region is empty.
  - NA4: [addr[i] << 2, +4).
  - NAPOT: t = count of trailing ones in addr[i]. Size = 2^(t+3) bytes; base = (addr[i] with low t bits cleared) << 2. All-ones addr gives t = 32, which covers the whole 2^34 space.
  - OFF: never matches.
- **Match classes:**
  - Full: the first and last byte are both in the region.
  - Partial: exactly one of the first and last byte is in the region.
  - None: neither byte is in the region.
- **FSM IDLE -> SCAN -> RESP -> IDLE:**
  - IDLE: req_valid & req_ready latches addr, size, type and priv, sets idx = 0, and moves to SCAN.
  - SCAN: evaluates entry idx using the register values current in that cycle.
    - Full or partial match: latch the result and go to RESP.
    - Otherwise, if idx == NUM_ENTRIES-1: latch the no-match result and go to RESP.
    - Otherwise: idx++.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE. A new request can be accepted in the cycle after RESP.
- **Latency:** a match at entry k gives resp_valid k+2 cycles after the acceptance edge. No match gives NUM_ENTRIES+1 cycles.
- **Result rules:**
  - Partial match: resp_allow = 0 in every privilege mode.
  - Full match with L = 0 and M-mode: allow = 1.
  - Full match otherwise: allow = the permission bit selected by req_type.
  - No match: allow = req_priv_m.
- **Response outputs:** hold their values outside RESP; only resp_valid pulses.
- **Mid-operation events:**
  - Reset during SCAN or RESP returns to IDLE with no response.
  - A CSR write during SCAN affects only entries evaluated after that write lands.

Decomposition:
- pmp_pkg holds:
  - the pmp_mode_e enum (OFF/TOR/NA4/NAPOT);
  - the access_e enum;
  - cfg bit-position localparams;
  - the pmp_cfg_t packed struct.
- Sub-module pmp_entry_match: combinational, one entry. Inputs are mode, addr[i], addr[i-1] (prev), req_addr and size. Outputs are full and partial. It generalises the single-mode NAPOT matcher, with trailing-ones decoding, NA4 and TOR.
- pmp_checker instantiates one pmp_entry_match, muxed by idx, and holds the registers and the FSM.

Test Plan:
- **NAPOT read/write:**
  - Setup: cfg0 = 0x1D (R|X|NAPOT), addr0 = 0x2000_01FF, which gives 4 KB at 0x8000_0000.
  - U-mode read at 0x8000_0FFC, size 4 -> resp_valid 2 cycles after accept; allow = 1, match = 1, entry = 0.
  - U-mode write to the same address -> allow = 0.
- **Partial match:** with the same setup, M-mode read at 0x8000_0FFE, size 4 -> match = 1, allow = 0.
- **TOR at entry 2:**
  - Setup: addr1 = 0x400, addr2 = 0x800, cfg2 = 0x0B.
  - U-mode write at 0x1FFC, size 4 -> allow = 1, entry = 2, resp 4 cycles after accept.
  - 0x2000 -> match = 0, allow = 0, resp 9 cycles after accept.
  - Repeat in M-mode -> allow = 1.
- **Lock:**
  - Setup: cfg1 = 0x89 (L|TOR|R).
  - Writes to addr0, addr1 and cfg1 -> csr_rdata unchanged.
  - M-mode write into region 1 -> allow = 0.
  - Writing cfg3 = 0x02 (W without R) -> reads back 0x00.
- **Reset mid-scan and back-to-back:**
  - Assert rst during SCAN -> resp_valid stays 0, req_ready = 1, all registers 0.
  - Back-to-back requests -> second accepted the cycle after RESP; each request yields exactly one response.
